// File: rtl/dfd_cla_pkg.sv
// Shared types and sizing for the CLA counter bank.
// The saturating counter build is selected with DFD_CLA_COUNTER_SATURATE_EN (see dfd_cla_counter).
package dfd_cla_pkg;

    localparam int CLA_NUMBER_OF_COUNTERS = 4;
    localparam int CLA_COUNTER_WIDTH      = 32;

    typedef struct packed {
        logic increment_pulse;
        logic clear_ctr;
        logic auto_increment;
        logic stop_auto_increment;
    } counter_controls;

    typedef enum logic {
        IDLE = 1'b0,
        AUTO = 1'b1
    } cla_ctr_state_e;

endpackage

// File: rtl/dfd_cla_counter.sv
// One CLA event counter slot: IDLE/AUTO FSM, count, sticky overflow and match edge.
// DFD_CLA_COUNTER_SATURATE_EN defined: saturate at all-ones; undefined: wrap to zero.
//
// state | meaning
// IDLE  | counts only on increment_pulse
// AUTO  | counts every enabled cycle until stop_auto_increment
module dfd_cla_counter
    import dfd_cla_pkg::*;
#(
    parameter int CNT_WIDTH = CLA_COUNTER_WIDTH
) (
    input  logic                 clock_i,
    input  logic                 reset_i,
    input  logic                 enable_eap_i,
    input  logic                 freeze_i,
    input  counter_controls      action_i,
    input  logic [CNT_WIDTH-1:0] target_i,
    input  logic                 overflow_clr_i,
    output logic [CNT_WIDTH-1:0] value_o,
    output logic                 match_o,
    output logic                 match_pulse_o,
    output logic                 overflow_o,
    output logic                 auto_active_o
);

    cla_ctr_state_e       state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 ovf_q, ovf_d;
    logic                 match_q, match_d;
    logic                 act_en;
    logic                 inc;
    logic                 at_max;
    logic                 match;

    assign act_en = enable_eap_i & ~freeze_i;
    assign at_max = &cnt_q;
    assign match  = (cnt_q == target_i);

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            match_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            match_q <= match_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        match_d = match_q;
        inc     = 1'b0;

        if (overflow_clr_i) begin
            ovf_d = 1'b0;
        end

        if (act_en) begin
            match_d = match;
            // Stop wins over start; a stop still lets this cycle's AUTO increment land.
            if (action_i.stop_auto_increment) begin
                state_d = IDLE;
            end else if (action_i.auto_increment) begin
                state_d = AUTO;
            end
            inc = action_i.increment_pulse || (state_q == AUTO) ||
                  (action_i.auto_increment && !action_i.stop_auto_increment);

            if (action_i.clear_ctr) begin
                cnt_d = '0;
            end else if (inc) begin
                if (at_max) begin
                    ovf_d = 1'b1;
`ifdef DFD_CLA_COUNTER_SATURATE_EN
                    cnt_d = cnt_q;
`else
                    cnt_d = '0;
`endif
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        end
    end

    assign value_o       = cnt_q;
    assign match_o       = match;
    assign match_pulse_o = match & ~match_q;
    assign overflow_o    = ovf_q;
    assign auto_active_o = (state_q == AUTO);

endmodule

// File: rtl/dfd_cla_counter_bank.sv
// Bank of CLA event counters fed by the action generator; one dfd_cla_counter per slot.
// Overflow behaviour follows DFD_CLA_COUNTER_SATURATE_EN inside the slot module.
module dfd_cla_counter_bank
    import dfd_cla_pkg::*;
#(
    parameter int CNT_WIDTH = CLA_COUNTER_WIDTH
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic                              enable_eap,
    input  logic                              freeze,
    input  counter_controls                   counter_actions     [CLA_NUMBER_OF_COUNTERS],
    input  logic [CNT_WIDTH-1:0]              counter_target      [CLA_NUMBER_OF_COUNTERS],
    input  logic [CLA_NUMBER_OF_COUNTERS-1:0] overflow_clr,
    output logic [CNT_WIDTH-1:0]              counter_value       [CLA_NUMBER_OF_COUNTERS],
    output logic [CLA_NUMBER_OF_COUNTERS-1:0] counter_match,
    output logic [CLA_NUMBER_OF_COUNTERS-1:0] counter_match_pulse,
    output logic [CLA_NUMBER_OF_COUNTERS-1:0] counter_overflow,
    output logic [CLA_NUMBER_OF_COUNTERS-1:0] counter_auto_active
);

    for (genvar g = 0; g < CLA_NUMBER_OF_COUNTERS; g++) begin : g_slot
        dfd_cla_counter #(
            .CNT_WIDTH(CNT_WIDTH)
        ) u_counter (
            .clock_i        (clock),
            .reset_i        (reset),
            .enable_eap_i   (enable_eap),
            .freeze_i       (freeze),
            .action_i       (counter_actions[g]),
            .target_i       (counter_target[g]),
            .overflow_clr_i (overflow_clr[g]),
            .value_o        (counter_value[g]),
            .match_o        (counter_match[g]),
            .match_pulse_o  (counter_match_pulse[g]),
            .overflow_o     (counter_overflow[g]),
            .auto_active_o  (counter_auto_active[g])
        );
    end

endmodule

// File: tb/tb_dfd_cla_counter_bank.sv
// Directed bench for dfd_cla_counter_bank built with a 4-bit counter width.
// Overflow expectations follow DFD_CLA_COUNTER_SATURATE_EN when it is defined for the build.
module tb_dfd_cla_counter_bank;
    import dfd_cla_pkg::*;

    localparam int W = 4;
    localparam int N = CLA_NUMBER_OF_COUNTERS;

    logic            clock = 1'b0;
    logic            reset;
    logic            enable_eap;
    logic            freeze;
    counter_controls acts [N];
    logic [W-1:0]    tgt  [N];
    logic [N-1:0]    ovf_clr;
    logic [W-1:0]    val  [N];
    logic [N-1:0]    match, mpulse, ovf, active;

    int checks = 0;
    int errors = 0;

    dfd_cla_counter_bank #(.CNT_WIDTH(W)) dut (
        .clock               (clock),
        .reset               (reset),
        .enable_eap          (enable_eap),
        .freeze              (freeze),
        .counter_actions     (acts),
        .counter_target      (tgt),
        .overflow_clr        (ovf_clr),
        .counter_value       (val),
        .counter_match       (match),
        .counter_match_pulse (mpulse),
        .counter_overflow    (ovf),
        .counter_auto_active (active)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic clr_acts();
        for (int i = 0; i < N; i++) acts[i] = '0;
        ovf_clr = '0;
    endtask

    task automatic test_reset();
        clr_acts();
        for (int i = 0; i < N; i++) tgt[i] = 4'd5;
        enable_eap = 1'b1;
        freeze     = 1'b0;
        reset      = 1'b1;
        step();
        step();
        reset = 1'b0;
        for (int i = 0; i < N; i++) begin
            checks++;
            if (val[i] !== 4'd0) begin
                errors++; $display("FAIL reset_val[%0d]: got %0d expected 0", i, val[i]);
            end
        end
        checks++;
        if ({ovf, active, match, mpulse} !== '0) begin
            errors++; $display("FAIL reset_flags: got ovf=%b act=%b match=%b pulse=%b expected all 0",
                               ovf, active, match, mpulse);
        end
    endtask

    task automatic test_pulse();
        tgt[0] = 4'd3;
        for (int i = 0; i < 3; i++) begin
            acts[0].increment_pulse = 1'b1;
            step();
            checks++;
            if (val[0] !== 4'(i + 1) || match[0] !== (i == 2) || mpulse[0] !== (i == 2)) begin
                errors++; $display("FAIL pulse_step%0d: got val=%0d match=%b pulse=%b expected val=%0d match=%b pulse=%b",
                                   i, val[0], match[0], mpulse[0], i + 1, i == 2, i == 2);
            end
        end
        acts[0].increment_pulse = 1'b0;
        step();
        checks++;
        if (val[0] !== 4'd3 || match[0] !== 1'b1 || mpulse[0] !== 1'b0) begin
            errors++; $display("FAIL pulse_hold: got val=%0d match=%b pulse=%b expected val=3 match=1 pulse=0",
                               val[0], match[0], mpulse[0]);
        end
        acts[0].clear_ctr = 1'b1;
        step();
        acts[0].clear_ctr = 1'b0;
        checks++;
        if (val[0] !== 4'd0 || match[0] !== 1'b0) begin
            errors++; $display("FAIL pulse_clear: got val=%0d match=%b expected val=0 match=0", val[0], match[0]);
        end
        step();
        tgt[0] = 4'd0;
        #1;
        checks++;
        if (match[0] !== 1'b1 || mpulse[0] !== 1'b1) begin
            errors++; $display("FAIL target_change_pulse: got match=%b pulse=%b expected 1 1", match[0], mpulse[0]);
        end
        tgt[0] = 4'd9;
        step();
    endtask

    task automatic test_auto();
        acts[1].auto_increment = 1'b1;
        step();
        acts[1].auto_increment = 1'b0;
        checks++;
        if (val[1] !== 4'd1 || active[1] !== 1'b1) begin
            errors++; $display("FAIL auto_start: got val=%0d active=%b expected val=1 active=1", val[1], active[1]);
        end
        for (int k = 0; k < 9; k++) begin
            step();
            checks++;
            if (val[1] !== 4'(k + 2) || active[1] !== 1'b1) begin
                errors++; $display("FAIL auto_run%0d: got val=%0d active=%b expected val=%0d active=1",
                                   k, val[1], active[1], k + 2);
            end
        end
        acts[1].stop_auto_increment = 1'b1;
        step();
        acts[1].stop_auto_increment = 1'b0;
        checks++;
        if (val[1] !== 4'd11 || active[1] !== 1'b0) begin
            errors++; $display("FAIL auto_stop: got val=%0d active=%b expected val=11 active=0", val[1], active[1]);
        end
        step();
        checks++;
        if (val[1] !== 4'd11) begin
            errors++; $display("FAIL auto_hold: got val=%0d expected 11", val[1]);
        end
        checks++;
        if (val[0] !== 4'd0 || val[2] !== 4'd0) begin
            errors++; $display("FAIL auto_isolation: got val0=%0d val2=%0d expected 0 0", val[0], val[2]);
        end
    endtask

    task automatic test_collision();
        acts[1].clear_ctr      = 1'b1;
        step();
        acts[1].clear_ctr      = 1'b0;
        acts[1].auto_increment = 1'b1;
        step();
        acts[1].auto_increment = 1'b0;
        repeat (4) step();
        checks++;
        if (val[1] !== 4'd5) begin
            errors++; $display("FAIL collision_setup: got val=%0d expected 5", val[1]);
        end
        acts[1].clear_ctr       = 1'b1;
        acts[1].increment_pulse = 1'b1;
        step();
        acts[1].clear_ctr       = 1'b0;
        acts[1].increment_pulse = 1'b0;
        checks++;
        if (val[1] !== 4'd0 || active[1] !== 1'b1) begin
            errors++; $display("FAIL collision_clear: got val=%0d active=%b expected val=0 active=1", val[1], active[1]);
        end
        step();
        checks++;
        if (val[1] !== 4'd1) begin
            errors++; $display("FAIL collision_resume: got val=%0d expected 1", val[1]);
        end
        acts[1].stop_auto_increment = 1'b1;
        step();
        acts[1].stop_auto_increment = 1'b0;
    endtask

    task automatic test_overflow();
        logic [W-1:0] exp1, exp2;
`ifdef DFD_CLA_COUNTER_SATURATE_EN
        exp1 = 4'd15; exp2 = 4'd15;
`else
        exp1 = 4'd0;  exp2 = 4'd1;
`endif
        acts[2].auto_increment = 1'b1;
        step();
        acts[2].auto_increment = 1'b0;
        repeat (13) step();
        acts[2].stop_auto_increment = 1'b1;
        step();
        acts[2].stop_auto_increment = 1'b0;
        checks++;
        if (val[2] !== 4'd15 || ovf[2] !== 1'b0 || active[2] !== 1'b0) begin
            errors++; $display("FAIL ovf_setup: got val=%0d ovf=%b active=%b expected val=15 ovf=0 active=0",
                               val[2], ovf[2], active[2]);
        end
        acts[2].increment_pulse = 1'b1;
        step();
        checks++;
        if (val[2] !== exp1 || ovf[2] !== 1'b1) begin
            errors++; $display("FAIL ovf_first: got val=%0d ovf=%b expected val=%0d ovf=1", val[2], ovf[2], exp1);
        end
        step();
        acts[2].increment_pulse = 1'b0;
        checks++;
        if (val[2] !== exp2 || ovf[2] !== 1'b1) begin
            errors++; $display("FAIL ovf_second: got val=%0d ovf=%b expected val=%0d ovf=1", val[2], ovf[2], exp2);
        end
        ovf_clr[2] = 1'b1;
        step();
        ovf_clr[2] = 1'b0;
        checks++;
        if (ovf[2] !== 1'b0 || val[2] !== exp2) begin
            errors++; $display("FAIL ovf_clear: got ovf=%b val=%0d expected ovf=0 val=%0d", ovf[2], val[2], exp2);
        end
    endtask

    task automatic test_freeze();
        acts[3].auto_increment = 1'b1;
        step();
        acts[3].auto_increment = 1'b0;
        freeze = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            checks++;
            if (val[3] !== 4'd1 || active[3] !== 1'b1) begin
                errors++; $display("FAIL freeze_hold%0d: got val=%0d active=%b expected val=1 active=1",
                                   k, val[3], active[3]);
            end
        end
        freeze = 1'b0;
        step();
        step();
        checks++;
        if (val[3] !== 4'd3) begin
            errors++; $display("FAIL freeze_resume: got val=%0d expected 3", val[3]);
        end
        enable_eap = 1'b0;
        acts[3].increment_pulse = 1'b1;
        repeat (4) step();
        checks++;
        if (val[3] !== 4'd3 || active[3] !== 1'b1) begin
            errors++; $display("FAIL enable_hold: got val=%0d active=%b expected val=3 active=1", val[3], active[3]);
        end
        acts[3].increment_pulse = 1'b0;
        enable_eap = 1'b1;
        step();
        checks++;
        if (val[3] !== 4'd4) begin
            errors++; $display("FAIL enable_resume: got val=%0d expected 4", val[3]);
        end
        acts[3].stop_auto_increment = 1'b1;
        step();
        acts[3].stop_auto_increment = 1'b0;
    endtask

    task automatic test_reset_mid_auto();
        acts[0].auto_increment = 1'b1;
        step();
        acts[0].auto_increment = 1'b0;
        repeat (6) step();
        checks++;
        if (val[0] !== 4'd7 || active[0] !== 1'b1) begin
            errors++; $display("FAIL rst_setup: got val=%0d active=%b expected val=7 active=1", val[0], active[0]);
        end
        tgt[0] = 4'd0;
        acts[0].increment_pulse = 1'b1;
        reset = 1'b1;
        step();
        reset = 1'b0;
        acts[0].increment_pulse = 1'b0;
        checks++;
        if (val[0] !== 4'd0 || active !== '0 || ovf !== '0) begin
            errors++; $display("FAIL rst_mid_auto: got val=%0d active=%b ovf=%b expected val=0 active=0 ovf=0",
                               val[0], active, ovf);
        end
        checks++;
        if (match[0] !== 1'b1 || mpulse[0] !== 1'b1) begin
            errors++; $display("FAIL rst_match_pulse: got match=%b pulse=%b expected 1 1", match[0], mpulse[0]);
        end
        step();
        checks++;
        if (match[0] !== 1'b1 || mpulse[0] !== 1'b0 || val[0] !== 4'd0) begin
            errors++; $display("FAIL rst_after: got match=%b pulse=%b val=%0d expected 1 0 0",
                               match[0], mpulse[0], val[0]);
        end
    endtask

    initial begin
        test_reset();
        test_pulse();
        test_auto();
        test_collision();
        test_overflow();
        test_freeze();
        test_reset_mid_auto();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dfd_cla_counter_bank.md
# dfd_cla_counter_bank

Bank of CLA event counters directly downstream of the CLA action generator. Consumes the per-counter `counter_controls` actions (increment pulse, clear, auto-increment start/stop) and maintains one counter per slot. Returns counter value, target-match and overflow status to the CLA node/event evaluation logic, closing the EAP loop. Status is also exposed to CSRs.

## Interface
- `CLA_NUMBER_OF_COUNTERS`, pkg value: number of counter slots.
- `CNT_WIDTH`, 32: counter and target width in bits.
- `clock`  in  1  single clock for the whole block.
- `reset`  in  1  synchronous, active-high reset.
- `enable_eap`  in  1  CLA enable; when low, all actions are ignored and counters hold.
- `freeze`  in  1  clock-halt freeze (from `clock_halt_local`); counters and state hold.
- `counter_actions`  in  `counter_controls [CLA_NUMBER_OF_COUNTERS]`  per-counter actions from the action generator, already registered.
- `counter_target`  in  `[CNT_WIDTH-1:0] [CLA_NUMBER_OF_COUNTERS]`  CSR match value per counter.
- `overflow_clr`  in  `CLA_NUMBER_OF_COUNTERS`  CSR W1C pulse; clears sticky overflow.
- `counter_value`  out  `[CNT_WIDTH-1:0] [CLA_NUMBER_OF_COUNTERS]`  current count.
- `counter_match`  out  `CLA_NUMBER_OF_COUNTERS`  level: `counter_value == counter_target`.
- `counter_match_pulse`  out  `CLA_NUMBER_OF_COUNTERS`  one-cycle pulse on the rising edge of `counter_match`.
- `counter_overflow`  out  `CLA_NUMBER_OF_COUNTERS`  sticky overflow flag.
- `counter_auto_active`  out  `CLA_NUMBER_OF_COUNTERS`  per-counter FSM is in AUTO.

## Operation
- Per-counter FSM with two states, IDLE and AUTO. Reset state is IDLE.
  - IDLE→AUTO on `auto_increment`.
  - AUTO→IDLE on `stop_auto_increment`.
  - `auto_increment` and `stop_auto_increment` in the same cycle: stop wins; the FSM ends in IDLE.
- Increment request per cycle = `increment_pulse` OR (state==AUTO, or entering AUTO this cycle).
  - Maximum +1 per cycle; a pulse during AUTO does not add 2.
  - A stop in the same cycle still allows that cycle's pulse.
- `clear_ctr` sets the count to 0 and overrides any increment in the same cycle.
  - Clear does not change FSM state; AUTO continues counting from 0 on the next cycle.
  - Clear does not clear overflow.
- Overflow: an increment at all-ones sets `counter_overflow`. Wrap or saturate behaviour is set under Configuration.
- `overflow_clr` clears overflow. If it coincides with a new overflow event, the set wins.
- `enable_eap`=0 or `freeze`=1: actions are ignored. Count, FSM, overflow and match history all hold. `overflow_clr` remains functional.
- `counter_match` is a compare on registered `counter_value` against live `counter_target`.
  - `counter_match_pulse` = match & ~match_q.
  - A target change that makes match true also produces a pulse.
- Reset values: `counter_value`=0, FSM=IDLE, `counter_overflow`=0, `match_q`=0, `counter_auto_active`=0.
  - `counter_match` after reset reflects 0==target. If target==0, a `counter_match_pulse` fires on the first cycle after reset.

## Timing
- Action sampled at cycle t → `counter_value` updated at t+1 → `counter_match` valid in t+1, `counter_match_pulse` in t+1.
- `auto_increment` at t: value +1 at t+1, then +1 every cycle while in AUTO.
- `stop_auto_increment` at t: last auto increment is visible at t+1, then the count holds.
- `counter_overflow` asserts in the same cycle the wrap or saturation becomes visible on `counter_value`.
- Reset asserted mid-count: all state returns to reset values at the next edge; actions in that cycle are discarded.

## Configuration
- Macro `DFD_CLA_COUNTER_SATURATE_EN`.
  - Defined: counter saturates at `{CNT_WIDTH{1'b1}}`; further increments hold the value and keep overflow set.
  - Undefined: counter wraps to 0 and sets overflow.

## Structure
- `dfd_cla_pkg` owns:
  - `counter_controls`;
  - `CLA_NUMBER_OF_COUNTERS`;
  - a new `cla_ctr_state_e` enum (IDLE, AUTO);
  - `CLA_COUNTER_WIDTH` (default for `CNT_WIDTH`).
- Sub-module `dfd_cla_counter`: one counter slot (FSM, count, overflow, match edge). Instantiated per slot in a generate loop; the bank is wiring only.

## Test plan
- Pulse: `increment_pulse` ×3 on consecutive cycles, target=3 → value 1,2,3 at t+1..t+3; match high from t+3; pulse only at t+3.
- Auto: `auto_increment` at t0, `stop_auto_increment` at t0+10 → value 11 and holding; `counter_auto_active` high t0+1..t0+10.
- Collision: in AUTO with value 5, `clear_ctr` + `increment_pulse` in the same cycle → value 0 next cycle, 1 the cycle after; FSM stays AUTO.
- Overflow, CNT_WIDTH=4, value 15, pulse:
  - without the macro → value 0, overflow=1;
  - with the macro → value 15, overflow=1;
  - `overflow_clr` → 0.
- Freeze/enable: `freeze`=1 during AUTO for 4 cycles → value constant. Release → counting resumes +1/cycle. Same result with `enable_eap`=0.
- Reset mid-AUTO at value 7 → next cycle value 0, IDLE, overflow 0; target=0 → `counter_match_pulse` on the first cycle after reset.
